// File: rtl/icb_sram_slave.sv
// rtl/icb_sram_slave.sv - ICB target backed by a word-addressed single-port SRAM with in-order response FIFO
//
// Purpose:
//   Accepts one ICB command per cycle, performs byte-masked writes and reads
//   against a 2^AW x 32-bit SRAM, and queues one response per command in a
//   small FIFO so that icb_rsp_ready backpressure never drops a response.
//
// Parameters:
//   BASE_ADDR  byte address of word 0, aligned to 4*2^AW
//   AW         word-address width (depth = 2^AW words)
//   RSP_DEPTH  response FIFO entries, power of two, >= 2
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   icb_cmd_valid/ready         command handshake
//   icb_cmd_addr                byte address
//   icb_cmd_read                1 = read, 0 = write
//   icb_cmd_wdata/wmask         write data and byte enables
//   icb_rsp_valid/ready         response handshake (valid = FIFO not empty)
//   icb_rsp_rdata               read data, 0 for writes and errors
//   icb_rsp_err                 address error (out of range or misaligned)

module icb_sram_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int          AW        = 10,
    parameter int          RSP_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        icb_cmd_valid,
    output logic        icb_cmd_ready,
    input  logic [31:0] icb_cmd_addr,
    input  logic        icb_cmd_read,
    input  logic [31:0] icb_cmd_wdata,
    input  logic [3:0]  icb_cmd_wmask,
    output logic        icb_rsp_valid,
    input  logic        icb_rsp_ready,
    output logic [31:0] icb_rsp_rdata,
    output logic        icb_rsp_err
);

    localparam int              PW       = $clog2(RSP_DEPTH);
    localparam int              CW       = PW + 1;
    localparam int              DEPTH    = 1 << AW;
    localparam logic [CW-1:0]   FULL_CNT = CW'(RSP_DEPTH);

    // SRAM array: intentionally not reset, contents survive rst_n.
    logic [31:0] mem [DEPTH];

    logic [31:0]   fifo_rdata_q [RSP_DEPTH];
    logic [31:0]   fifo_rdata_d [RSP_DEPTH];
    logic          fifo_err_q   [RSP_DEPTH];
    logic          fifo_err_d   [RSP_DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          acc;
    logic          pop;
    logic          hit;
    logic          mem_we;
    logic [AW-1:0] word_idx;
    logic [31:0]   push_rdata;
    logic          push_err;

    assign icb_rsp_valid = (count_q != '0);
    assign pop           = icb_rsp_valid & icb_rsp_ready;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign icb_cmd_ready = (count_q != FULL_CNT) | pop;
    assign acc           = icb_cmd_valid & icb_cmd_ready;

    // BASE_ADDR is aligned to the window size, so a range check reduces to
    // comparing the upper address bits.
    assign word_idx = icb_cmd_addr[AW+1:2];
    assign hit      = (icb_cmd_addr[1:0] == 2'b00) &&
                      (icb_cmd_addr[31:AW+2] == BASE_ADDR[31:AW+2]);
    assign mem_we   = acc & hit & ~icb_cmd_read;

    // Read data is captured into the FIFO at the accepting edge, so it
    // reflects the memory contents before any write on that same edge.
    assign push_rdata = (hit && icb_cmd_read) ? mem[word_idx] : 32'h0;
    assign push_err   = ~hit;

    assign icb_rsp_rdata = fifo_rdata_q[rptr_q];
    assign icb_rsp_err   = fifo_err_q[rptr_q];

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (icb_cmd_wmask[i]) begin
                    mem[word_idx][8*i +: 8] <= icb_cmd_wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        count_d      = count_q;
        fifo_rdata_d = fifo_rdata_q;
        fifo_err_d   = fifo_err_q;

        if (acc) begin
            fifo_rdata_d[wptr_q] = push_rdata;
            fifo_err_d[wptr_q]   = push_err;
            wptr_d               = wptr_q + PW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PW'(1);
        end

        case ({acc, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                fifo_rdata_q[i] <= 32'h0;
                fifo_err_q[i]   <= 1'b0;
            end
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            fifo_rdata_q <= fifo_rdata_d;
            fifo_err_q   <= fifo_err_d;
        end
    end

endmodule
